tag_alloc_arbiter: RTL
======================

// Module: tag_alloc_arbiter
// PURPOSE
//   Shares a pool of 2**TAG_W transaction tags between NUM_REQ requesters.
//   - Keeps a free/busy bitmap.
//   - Grants requesters round-robin and hands out free tags next-fit from a rotating search pointer.
//   - Accepts tag releases and reports errors for bad releases.
//   - Provides a flush/drain sequence that stops new grants until every tag is back.
//   Sits between the request generators and the tag-remapping scoreboard.
// PARAMETERS
//   NUM_REQ  4  number of requesters (>=2)
//   TAG_W    4  tag width; pool size TOTAL = 2**TAG_W
// PORTS
//   i_clk           in   1            clock, all state on rising edge
//   i_rst           in   1            synchronous reset, active-high
//   i_req           in   NUM_REQ      per-requester allocation request (level)
//   o_gnt           out  NUM_REQ      one-hot grant; the tag is consumed in any cycle it is set
//   o_gnt_tag       out  TAG_W        tag allocated to the granted requester (valid when |o_gnt)
//   i_rel_valid     in   1            release strobe
//   i_rel_tag       in   TAG_W        tag being released
//   i_flush_req     in   1            request drain; sampled in RUN only
//   o_flush_done    out  1            one-cycle pulse: all tags free after drain
//   o_free_cnt      out  TAG_W+1      registered count of free tags
//   o_err           out  1            sticky: release of a tag not currently allocated
// BEHAVIOUR
//   Reset (i_rst=1 at an edge)
//     - Bitmap all-free; search ptr=0; round-robin ptr=0; state=RUN.
//     - o_free_cnt=TOTAL; o_err=0; o_flush_done=0.
//     - o_gnt is 0 during reset.
//     - Reset mid-operation discards all allocations; no releases are required afterwards.
//   Grant (combinational from registered state + i_req)
//     - Conditions: state==RUN, |i_req, and o_free_cnt!=0.
//     - Winner: the first set i_req bit at or after rr_ptr, wrapping.
//     - o_gnt_tag: the first free bitmap index at or after search_ptr, mod TOTAL.
//     - Zero-cycle latency: request and grant occur in the same cycle.
//     - At most one grant per cycle.
//     - A requester holding i_req high receives a new tag on every cycle it wins.
//   On a grant edge
//     - bitmap[tag] <= busy.
//     - search_ptr <= tag+1 (wraps at TOTAL).
//     - rr_ptr <= winner+1 (wraps at NUM_REQ).
//   No grant: both pointers hold.
//   Release
//     - If i_rel_valid and bitmap[i_rel_tag] is busy: bit <= free at the edge.
//     - If the bit is already free: o_err <= 1 (sticky until reset); bitmap and count are unchanged.
//   Simultaneous grant + release in the same cycle
//     - Both take effect.
//     - o_free_cnt nets to unchanged.
//     - A tag freed this cycle is not grantable until the next cycle, because the search uses registered bitmap state.
//     - The release tag equal to the grant tag cannot occur (the grant tag is free, so that release is an error case; o_err sets and the grant still applies).
//   o_free_cnt
//     - Updated each edge: +1 for a valid release, -1 for a grant.
//     - Never exceeds TOTAL and never goes below 0.
//   Full pool (o_free_cnt==0): no grant; requests wait, no error.
//   FSM
//     - RUN:   grants enabled.
//       - i_flush_req=1 -> DRAIN.
//     - DRAIN: grants blocked, releases processed.
//       - When o_free_cnt==TOTAL -> DONE.
//     - DONE:  o_flush_done=1 for exactly this cycle.
//       - Next cycle -> RUN.
//     - Flush on an already-empty pool: RUN -> DRAIN -> DONE, so the pulse comes 2 cycles after i_flush_req.
//     - i_flush_req is ignored in DRAIN and DONE.
// TESTING
//   1. Reset, i_req=0001 held 3 cycles
//      -> grants tags 0,1,2 to req0 on consecutive cycles; o_free_cnt 16->13.
//   2. i_req=1111 held 4 cycles from reset
//      -> o_gnt 0001,0010,0100,1000; tags 0,1,2,3; rr_ptr wraps to 0.
//   3. Allocate all 16 tags; keep i_req=0010 high
//      -> o_gnt=0 while full.
//      -> Release tag 5: grant of tag 5 appears the cycle after the release edge.
//   4. Release tag 7 while tag 7 is free
//      -> o_err=1 next cycle and stays 1; o_free_cnt unchanged.
//   5. Hold 3 tags; pulse i_flush_req with i_req=1111
//      -> no grants.
//      -> Release all 3 tags: o_flush_done pulses 1 cycle after o_free_cnt reaches 16; grants resume.
//   6. Grant and release of a different tag in the same cycle -> o_free_cnt unchanged.
//      Assert i_rst mid-traffic -> free cnt 16 and pointers 0 next cycle.

Source files
------------

// File: rtl/tag_alloc_arbiter.sv
// Tag pool allocator: round-robin grant among requesters, next-fit tag search from a
// rotating pointer, release checking, and a flush/drain sequence that waits for all tags.
module tag_alloc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [TAG_W-1:0]   o_gnt_tag,
   input  logic               i_rel_valid,
   input  logic [TAG_W-1:0]   i_rel_tag,
   input  logic               i_flush_req,
   output logic               o_flush_done,
   output logic [TAG_W:0]     o_free_cnt,
   output logic               o_err,
   output logic [1:0]         o_dbg_state
);

   localparam int TOTAL = 1 << TAG_W;
   localparam int RR_W  = $clog2(NUM_REQ);
   localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(TOTAL);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TOTAL-1:0]  free_map;
   logic [TAG_W-1:0]  search_ptr;
   logic [RR_W-1:0]   rr_ptr;
   logic [TAG_W:0]    free_cnt;
   logic              err;

   logic [RR_W-1:0]   req_cand;
   logic [RR_W-1:0]   winner;
   logic              req_found;
   logic [RR_W-1:0]   next_rr;
   logic [TAG_W-1:0]  tag_cand;
   logic [TAG_W-1:0]  gnt_tag;
   logic              tag_found;
   logic              gnt_en;
   logic              rel_ok;
   logic              rel_bad;

   // Round-robin winner: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      req_cand  = '0;
      winner    = '0;
      req_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_cand = RR_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!req_found && i_req[req_cand]) begin
            req_found = 1'b1;
            winner    = req_cand;
         end
      end
   end

   // Next-fit tag: first free index at or after search_ptr; the pointer wraps by width.
   always_comb begin
      tag_cand  = '0;
      gnt_tag   = '0;
      tag_found = 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
         tag_cand = search_ptr + TAG_W'(i);
         if (!tag_found && free_map[tag_cand]) begin
            tag_found = 1'b1;
            gnt_tag   = tag_cand;
         end
      end
   end

   assign next_rr = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
   assign gnt_en  = !i_rst && (state == ST_RUN) && req_found &&
                    (free_cnt != '0) && tag_found;
   assign rel_ok  = i_rel_valid && !free_map[i_rel_tag];
   assign rel_bad = i_rel_valid && free_map[i_rel_tag];

   assign o_gnt        = gnt_en ? (NUM_REQ'(1) << winner) : '0;
   assign o_gnt_tag    = gnt_tag;
   assign o_flush_done = (state == ST_DONE);
   assign o_free_cnt   = free_cnt;
   assign o_err        = err;
   assign o_dbg_state  = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (i_flush_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (free_cnt == CNT_FULL) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // A successful release never targets the grant tag (that one is free), so the two
   // bitmap writes below always hit different bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_RUN;
         free_map   <= '1;
         search_ptr <= '0;
         rr_ptr     <= '0;
         free_cnt   <= CNT_FULL;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (gnt_en) begin
            free_map[gnt_tag] <= 1'b0;
            search_ptr        <= gnt_tag + TAG_W'(1);
            rr_ptr            <= next_rr;
         end
         if (rel_ok) begin
            free_map[i_rel_tag] <= 1'b1;
         end
         if (rel_bad) begin
            err <= 1'b1;
         end
         case ({gnt_en, rel_ok})
            2'b10:   free_cnt <= free_cnt - (TAG_W+1)'(1);
            2'b01:   free_cnt <= free_cnt + (TAG_W+1)'(1);
            default: free_cnt <= free_cnt;
         endcase
      end
   end

endmodule
